// File: rtl/bcd_to_bin.sv
// Sequential signed-decimal to two's-complement converter using reverse double-dabble.
// start/busy/done handshake; illegal digits and out-of-range magnitudes are flagged.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      bin_out,
  output logic                  err_digit,
  output logic                  err_range
);

  localparam int unsigned MW   = 4 * DIGITS;
  localparam int unsigned ITER = MW;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned EW   = ((MW > WIDTH) ? MW : WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    bcd_q, bcd_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             dig_bad_q, dig_bad_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             err_digit_q, err_digit_d;
  logic             err_range_q, err_range_d;

  function automatic logic any_digit_bad(input logic [MW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One reverse double-dabble step on the combined {bcd, mag} register.
  function automatic logic [2*MW-1:0] shift_step(input logic [MW-1:0] b,
                                                 input logic [MW-1:0] m);
    logic [2*MW-1:0] sr;
    sr = {b, m} >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr[MW + 4*i +: 4] >= 4'd8) sr[MW + 4*i +: 4] = sr[MW + 4*i +: 4] - 4'd3;
    end
    return sr;
  endfunction

  // Range test on the full-width magnitude, before truncation.
  logic [EW-1:0]    mag_ext;
  logic [EW-1:0]    mag_hi;
  logic             pos_ok;
  logic             neg_ok;
  logic [WIDTH-1:0] mag_trunc;

  always_comb begin
    mag_ext   = EW'(mag_q);
    mag_hi    = mag_ext >> (WIDTH - 1);
    pos_ok    = (mag_hi == '0);
    neg_ok    = pos_ok || (mag_ext == (EW'(1) << (WIDTH - 1)));
    mag_trunc = mag_ext[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    dig_bad_d   = dig_bad_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bin_d       = bin_q;
    err_digit_d = err_digit_q;
    err_range_d = err_range_q;

    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          bcd_d     = bcd_in;
          mag_d     = '0;
          neg_d     = neg;
          dig_bad_d = any_digit_bad(bcd_in);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end

      StShift: begin
        // Terminal count takes one extra edge with no shift before FINISH.
        if (cnt_q == CW'(ITER)) begin
          state_d = StFinish;
        end else begin
          {bcd_d, mag_d} = shift_step(bcd_q, mag_q);
          cnt_d          = cnt_q + 1'b1;
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (dig_bad_q) begin
          bin_d       = '0;
          err_digit_d = 1'b1;
          err_range_d = 1'b0;
        end else if ((!neg_q && !pos_ok) || (neg_q && !neg_ok)) begin
          bin_d       = '0;
          err_digit_d = 1'b0;
          err_range_d = 1'b1;
        end else begin
          bin_d       = neg_q ? (WIDTH'(0) - mag_trunc) : mag_trunc;
          err_digit_d = 1'b0;
          err_range_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bcd_q       <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      dig_bad_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bin_q       <= '0;
      err_digit_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      dig_bad_q   <= dig_bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bin_q       <= bin_d;
      err_digit_q <= err_digit_d;
      err_range_q <= err_range_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bin_out   = bin_q;
  assign err_digit = err_digit_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: driver pushes expected results at accept,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LAT    = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             neg = 1'b0;
  logic [11:0]      bcd_in = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] bin_out;
  logic             err_digit;
  logic             err_range;

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .neg       (neg),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .err_digit (err_digit),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  bin;
    logic        ed;
    logic        er;
    int unsigned at;
  } exp_t;

  typedef struct {
    logic [11:0] bcd;
    logic        n;
    logic [7:0]  bin;
    logic        ed;
    logic        er;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bin_out", 32'(bin_out), 32'(e.bin));
        chk("err_digit", 32'(err_digit), 32'(e.ed));
        chk("err_range", 32'(err_range), 32'(e.er));
        chk("latency_cycle", cyc, e.at);
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic ed, input logic er,
                          input int unsigned at);
    exp_t e;
    e.bin = b;
    e.ed  = ed;
    e.er  = er;
    e.at  = at;
    sb.push_back(e);
  endtask

  // Returns the cycle index seen at the negedge right after the accept edge.
  task automatic issue(input logic [11:0] b, input logic n, output int unsigned acc);
    @(negedge clk);
    bcd_in = b;
    neg    = n;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("done_timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  vec_t vecs[10] = '{
    '{12'h127, 1'b0, 8'h7F, 1'b0, 1'b0},
    '{12'h128, 1'b1, 8'h80, 1'b0, 1'b0},
    '{12'h128, 1'b0, 8'h00, 1'b0, 1'b1},
    '{12'h1A5, 1'b0, 8'h00, 1'b1, 1'b0},
    '{12'h999, 1'b1, 8'h00, 1'b0, 1'b1},
    '{12'h000, 1'b1, 8'h00, 1'b0, 1'b0},
    '{12'h099, 1'b0, 8'h63, 1'b0, 1'b0},
    '{12'h005, 1'b1, 8'hFB, 1'b0, 1'b0},
    '{12'h0F0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{12'h045, 1'b1, 8'hD3, 1'b0, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int          n0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_err_digit", 32'(err_digit), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      issue(vecs[k].bcd, vecs[k].n, acc);
      push_exp(vecs[k].bin, vecs[k].ed, vecs[k].er, acc + LAT);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("bin_out_held", 32'(bin_out), 32'(vecs[k].bin));
    end

    // Reset in the middle of a conversion aborts it.
    n0 = n_done;
    chk("pre_abort_bin_out", 32'(bin_out), 32'hD3);
    issue(12'h100, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bin_out", 32'(bin_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err_range", 32'(err_range), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'(n0));

    // start while busy is ignored
    n0 = n_done;
    issue(12'h064, 1'b0, acc);
    push_exp(8'h40, 1'b0, 1'b0, acc + LAT);
    repeat (4) @(negedge clk);
    bcd_in = 12'h999;
    neg    = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);
    chk("ignored_start_single_done", 32'(n_done), 32'(n0 + 1));

    // start held high: back-to-back conversions, inputs change while busy
    n0 = n_done;
    @(negedge clk);
    bcd_in = 12'h033;
    neg    = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    acc = cyc;
    push_exp(8'h21, 1'b0, 1'b0, acc + LAT);
    push_exp(8'hF4, 1'b0, 1'b0, acc + LAT + 1 + LAT);
    bcd_in = 12'h012;
    neg    = 1'b1;
    repeat (15) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("back_to_back_dones", 32'(n_done), 32'(n0 + 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
